// File: rtl/demux_wr_router.sv
// demux_wr_router: routes one write request to one of N_CH channels and
// holds the strobe until that channel acks, or aborts on bad select/timeout.
//
// Ports:
//   clk_i      system clock (rising edge)
//   rst_n_i    asynchronous active-low reset
//   wr_i       write request, sampled only when idle
//   reg_sel_i  target channel select (values >= N_CH are invalid)
//   data_i     write data
//   ack_i      per-channel write acknowledge
//   wr_o       one-hot routed write strobe, zero when idle
//   data_o     captured write data, shared by all channels
//   busy_o     transfer in progress, requests ignored while high
//   done_o     one-cycle pulse on acknowledged completion
//   err_o      one-cycle pulse on invalid select or timeout
module demux_wr_router #(
    parameter int N_CH    = 4,
    parameter int SEL_W   = $clog2(N_CH),
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wr_i,
    input  logic [SEL_W-1:0]  reg_sel_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [N_CH-1:0]   ack_i,
    output logic [N_CH-1:0]   wr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_CH-1:0]   hot;
    logic              sel_ok;
    logic              ack_hit;
    logic              tmo;

    // One extra bit so N_CH fits even when SEL_W is the minimum width.
    assign sel_ok = ({1'b0, reg_sel_i} < (SEL_W + 1)'(N_CH));

    always_comb begin
        hot = '0;
        for (int i = 0; i < N_CH; i++) begin
            hot[i] = (sel_q == SEL_W'(i));
        end
    end

    // Only the captured channel's ack counts.
    assign ack_hit = |(ack_i & hot);
    assign tmo     = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (wr_i) begin
                    if (sel_ok) begin
                        sel_d   = reg_sel_i;
                        data_d  = data_i;
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q != CNT_W'(TIMEOUT)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Ack takes priority over a coincident timeout.
                if (ack_hit) begin
                    state_d = S_DONE;
                end else if (tmo) begin
                    state_d = S_ERR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wr_o   = (state_q == S_WAIT) ? hot : '0;
    assign data_o = data_q;
    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_DONE);
    assign err_o  = (state_q == S_ERR);

endmodule

// File: tb/tb_demux_wr_router.sv
// tb_demux_wr_router: directed table, corner sequences and randomized
// transactions against a transaction-level model of the router.
module tb_demux_wr_router;

    logic        clk;
    logic        rst_n;
    logic        wr;
    logic [2:0]  sel;
    logic [31:0] dat;
    logic [3:0]  ack;
    logic [3:0]  wr_o;
    logic [31:0] data_o;
    logic        busy_o, done_o, err_o;

    logic        wr3;
    logic [1:0]  sel3;
    logic [31:0] dat3;
    logic [2:0]  ack3;
    logic [2:0]  wr3_o;
    logic [31:0] data3_o;
    logic        busy3_o, done3_o, err3_o;

    int n_chk  = 0;
    int n_pass = 0;

    demux_wr_router #(
        .N_CH(4), .SEL_W(3), .DATA_W(32), .TIMEOUT(15)
    ) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .wr_i(wr), .reg_sel_i(sel),
        .data_i(dat), .ack_i(ack), .wr_o(wr_o), .data_o(data_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    demux_wr_router #(
        .N_CH(3), .SEL_W(2), .DATA_W(32), .TIMEOUT(15)
    ) u_dut3 (
        .clk_i(clk), .rst_n_i(rst_n), .wr_i(wr3), .reg_sel_i(sel3),
        .data_i(dat3), .ack_i(ack3), .wr_o(wr3_o), .data_o(data3_o),
        .busy_o(busy3_o), .done_o(done3_o), .err_o(err3_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  sel;
        logic [31:0] dat;
        logic [3:0]  ack;
        logic [3:0]  ew;
        logic        eb;
        logic        ed;
        logic        ee;
        logic [31:0] edat;
    } vec_t;

    vec_t tbl [0:14];

    function automatic logic [63:0] obs();
        return {25'd0, wr_o, busy_o, done_o, err_o, data_o};
    endfunction

    function automatic logic [63:0] ex(logic [3:0] w, logic b, logic d,
                                       logic e, logic [31:0] x);
        return {25'd0, w, b, d, e, x};
    endfunction

    function automatic logic [63:0] obs3();
        return {58'd0, wr3_o, busy3_o, done3_o, err3_o};
    endfunction

    function automatic logic [63:0] ex3(logic [2:0] w, logic b, logic d,
                                        logic e);
        return {58'd0, w, b, d, e};
    endfunction

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] last;
    logic [3:0]  oh;
    logic [3:0]  noise;
    int          s, d, k;
    bit          fin;

    initial begin
        rst_n = 1'b0;
        wr = 0; sel = 0; dat = 0; ack = 0;
        wr3 = 0; sel3 = 0; dat3 = 0; ack3 = 0;
        #3;
        chk("reset", obs(), ex(4'b0, 0, 0, 0, 32'h0));
        chk("reset3", obs3(), ex3(3'b0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        tbl[0]  = '{1, 3'd2, 32'hDEADBEEF, 4'b0100, 4'b0100, 1, 0, 0, 32'hDEADBEEF};
        tbl[1]  = '{0, 3'd2, 32'h0,        4'b0100, 4'b0000, 1, 1, 0, 32'hDEADBEEF};
        tbl[2]  = '{0, 3'd0, 32'h0,        4'b0000, 4'b0000, 0, 0, 0, 32'hDEADBEEF};
        tbl[3]  = '{1, 3'd1, 32'h12345678, 4'b0000, 4'b0010, 1, 0, 0, 32'h12345678};
        tbl[4]  = '{0, 3'd3, 32'hAAAA5555, 4'b0001, 4'b0010, 1, 0, 0, 32'h12345678};
        tbl[5]  = '{1, 3'd0, 32'h0,        4'b0000, 4'b0010, 1, 0, 0, 32'h12345678};
        tbl[6]  = '{0, 3'd2, 32'hFFFFFFFF, 4'b0001, 4'b0010, 1, 0, 0, 32'h12345678};
        tbl[7]  = '{0, 3'd0, 32'h0,        4'b1101, 4'b0010, 1, 0, 0, 32'h12345678};
        tbl[8]  = '{0, 3'd0, 32'h0,        4'b0000, 4'b0010, 1, 0, 0, 32'h12345678};
        tbl[9]  = '{0, 3'd1, 32'h0,        4'b0010, 4'b0000, 1, 1, 0, 32'h12345678};
        tbl[10] = '{1, 3'd3, 32'hCAFEF00D, 4'b0000, 4'b0000, 0, 0, 0, 32'h12345678};
        tbl[11] = '{0, 3'd0, 32'h0,        4'b0000, 4'b0000, 0, 0, 0, 32'h12345678};
        tbl[12] = '{1, 3'd6, 32'h11111111, 4'b0000, 4'b0000, 1, 0, 1, 32'h12345678};
        tbl[13] = '{1, 3'd2, 32'h22222222, 4'b0100, 4'b0000, 0, 0, 0, 32'h12345678};
        tbl[14] = '{0, 3'd0, 32'h0,        4'b0000, 4'b0000, 0, 0, 0, 32'h12345678};

        for (int i = 0; i < 15; i++) begin
            wr = tbl[i].wr; sel = tbl[i].sel;
            dat = tbl[i].dat; ack = tbl[i].ack;
            tick();
            chk($sformatf("tbl%0d", i), obs(),
                ex(tbl[i].ew, tbl[i].eb, tbl[i].ed, tbl[i].ee, tbl[i].edat));
        end

        // Timeout: 15 strobe cycles then an error pulse.
        wr = 1; sel = 3'd3; dat = 32'h0BADF00D; ack = 4'b0111;
        tick();
        chk("tmo_w1", obs(), ex(4'b1000, 1, 0, 0, 32'h0BADF00D));
        wr = 0;
        for (int c = 2; c <= 15; c++) begin
            tick();
            chk($sformatf("tmo_w%0d", c), obs(),
                ex(4'b1000, 1, 0, 0, 32'h0BADF00D));
        end
        tick();
        chk("tmo_err", obs(), ex(4'b0, 1, 0, 1, 32'h0BADF00D));
        ack = 0;
        tick();
        chk("tmo_idle", obs(), ex(4'b0, 0, 0, 0, 32'h0BADF00D));

        // Ack arriving in the last wait cycle beats the timeout.
        wr = 1; sel = 3'd0; dat = 32'h5A5A0001;
        tick();
        wr = 0;
        for (int c = 2; c <= 15; c++) tick();
        chk("late_w15", obs(), ex(4'b0001, 1, 0, 0, 32'h5A5A0001));
        ack = 4'b0001;
        tick();
        chk("late_done", obs(), ex(4'b0, 1, 1, 0, 32'h5A5A0001));
        ack = 0;
        tick();
        chk("late_idle", obs(), ex(4'b0, 0, 0, 0, 32'h5A5A0001));

        // Three-channel instance: select 3 is out of range.
        wr3 = 1; sel3 = 2'd3; dat3 = 32'h33;
        tick();
        chk("inv3_err", obs3(), ex3(3'b0, 1, 0, 1));
        sel3 = 2'd0;
        tick();
        chk("inv3_drop", obs3(), ex3(3'b0, 0, 0, 0));
        chk("inv3_data", {32'd0, data3_o}, 64'h0);
        wr3 = 0;
        tick();
        chk("inv3_idle", obs3(), ex3(3'b0, 0, 0, 0));

        // Reset in the middle of a wait.
        wr = 1; sel = 3'd0; dat = 32'h00000077;
        tick();
        wr = 0;
        tick();
        chk("rst_wait", obs(), ex(4'b0001, 1, 0, 0, 32'h77));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", obs(), ex(4'b0, 0, 0, 0, 32'h0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_after", obs(), ex(4'b0, 0, 0, 0, 32'h0));
        wr = 1; sel = 3'd3; dat = 32'h0000ABCD; ack = 4'b1000;
        tick();
        chk("rst_req", obs(), ex(4'b1000, 1, 0, 0, 32'hABCD));
        wr = 0;
        tick();
        chk("rst_done", obs(), ex(4'b0, 1, 1, 0, 32'hABCD));
        ack = 0;
        tick();
        chk("rst_idle", obs(), ex(4'b0, 0, 0, 0, 32'hABCD));

        // Randomized transactions against a transaction-level model.
        last = 32'hABCD;
        for (int t = 0; t < 60; t++) begin
            s = $urandom_range(0, 5);
            d = $urandom_range(0, 17);
            wr = 1; sel = 3'(s); dat = $urandom; ack = 4'($urandom);
            tick();
            if (s >= 4) begin
                chk($sformatf("r%0d_inv", t), obs(), ex(4'b0, 1, 0, 1, last));
            end else begin
                last = dat;
                oh = 4'b0001 << s;
                chk($sformatf("r%0d_w1", t), obs(), ex(oh, 1, 0, 0, last));
                k = 1;
                fin = 0;
                while (!fin) begin
                    noise = 4'($urandom);
                    ack = (noise & ~oh) | ((k == d + 1) ? oh : 4'b0);
                    wr = 1'($urandom); sel = 3'($urandom); dat = $urandom;
                    tick();
                    if (k == d + 1) begin
                        chk($sformatf("r%0d_done", t), obs(),
                            ex(4'b0, 1, 1, 0, last));
                        fin = 1;
                    end else if (k == 15) begin
                        chk($sformatf("r%0d_tmo", t), obs(),
                            ex(4'b0, 1, 0, 1, last));
                        fin = 1;
                    end else begin
                        k++;
                        chk($sformatf("r%0d_w%0d", t, k), obs(),
                            ex(oh, 1, 0, 0, last));
                    end
                end
            end
            wr = 1'($urandom); sel = 3'($urandom);
            dat = $urandom; ack = 4'($urandom);
            tick();
            chk($sformatf("r%0d_end", t), obs(), ex(4'b0, 0, 0, 0, last));
            wr = 0;
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                tick();
                chk($sformatf("r%0d_gap", t), obs(), ex(4'b0, 0, 0, 0, last));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/demux_wr_router.md
Name: demux_wr_router

Overview:
- Parametrised successor to the 1:2 write-strobe demux in the peripheral register path.
- Routes a single write request, with its data, to one of N_CH register/peripheral channels.
- Holds the routed strobe until the target channel acknowledges it.
- Aborts with an error flag on an invalid select or on a timeout.
- Sits between the bus-side peripheral interface and the per-register write ports (SPI ctrl/data and similar).

Parameters:
- N_CH, 4: number of output channels; must be >= 2.
- SEL_W, $clog2(N_CH): width of the channel select; may exceed the minimum, and values >= N_CH are invalid.
- DATA_W, 32: width of the write data.
- TIMEOUT, 15: cycles to wait for ack_i before aborting; must be >= 1.

Ports:
- clk_i, input, 1: system clock, rising edge.
- rst_n_i, input, 1: asynchronous active-low reset.
- wr_i, input, 1: write request; sampled only while not busy.
- reg_sel_i, input, SEL_W: target channel select.
- data_i, input, DATA_W: write data.
- ack_i, input, N_CH: per-channel write acknowledge, one bit per channel.
- wr_o, output, N_CH: one-hot routed write strobe; all zero when idle.
- data_o, output, DATA_W: captured write data, common to all channels.
- busy_o, output, 1: transfer in progress; new requests are ignored while high.
- done_o, output, 1: one-cycle pulse when a transfer completes with ack.
- err_o, output, 1: one-cycle pulse on an invalid select or a timeout.

Behaviour:
- Reset (asynchronous, rst_n_i=0):
  - wr_o=0, data_o=0, busy_o=0, done_o=0, err_o=0.
  - FSM goes to IDLE; timeout counter goes to 0.
  - Reset asserted mid-transfer drops wr_o immediately, with no done/err pulse.
- FSM states: IDLE, WAIT, DONE, ERR.
- IDLE:
  - If wr_i=1 and reg_sel_i < N_CH: capture sel and data_i into registers, go to WAIT.
  - If wr_i=1 and reg_sel_i >= N_CH: go to ERR; no strobe is ever driven.
  - If wr_i=0: stay in IDLE.
- WAIT:
  - Outputs: wr_o[sel]=1 and all other bits 0; data_o=captured data; busy_o=1.
  - Counter increments every cycle in WAIT.
  - If ack_i[sel]=1: go to DONE.
  - Else if counter == TIMEOUT-1: go to ERR.
  - If ack and timeout coincide in the same cycle, ack wins: go to DONE.
  - ack_i bits of non-selected channels are ignored.
- DONE: wr_o=0, done_o=1, busy_o=1 for this cycle; next state IDLE.
- ERR: wr_o=0, err_o=1, busy_o=1 for this cycle; next state IDLE.
- Latency:
  - Strobe appears 1 cycle after wr_i is sampled.
  - If ack_i is already high in the first WAIT cycle, the strobe lasts exactly 1 cycle.
  - done_o pulses 1 cycle after the ack is seen.
  - Minimum request-to-request spacing is 3 cycles (IDLE, WAIT, DONE).
- Request handling:
  - wr_i is ignored in every state except IDLE; there is no queueing.
  - Upstream must hold or retry a request until busy_o=0.
  - A wr_i pulse arriving in DONE or ERR is dropped.
- Capture:
  - Select and data are captured only on the IDLE->WAIT transition.
  - Changes on reg_sel_i or data_i during WAIT have no effect.
- data_o keeps its last captured value after completion; it is not cleared.
- Counter:
  - Width is $clog2(TIMEOUT+1).
  - Cleared on entry to WAIT; saturates, never wraps.
- Invariants:
  - wr_o is always one-hot or zero.
  - Exactly one of done_o or err_o pulses per accepted request.
  - done_o and err_o are never high together.

Test Plan:
- Reset, then wr_i=1, reg_sel_i=2, data_i=0xDEADBEEF, with ack_i[2] high in the first WAIT cycle:
  - wr_o=4'b0100 for exactly 1 cycle with data_o=0xDEADBEEF.
  - done_o pulses the next cycle; busy_o high for 2 cycles.
- reg_sel_i=1 with ack_i[1] delayed by 5 cycles, and ack_i[0] pulsed meanwhile:
  - wr_o=4'b0010 held for 6 cycles.
  - The ack_i[0] pulse is ignored; a single done_o pulse follows.
- ack_i held at 0, TIMEOUT=15:
  - wr_o held for 15 cycles, then err_o pulses and busy_o falls.
- Ack on the timeout cycle: ack_i[sel] rises in WAIT cycle 15 → done_o=1, err_o stays 0.
- Invalid select:
  - With N_CH=3, SEL_W=2, reg_sel_i=3, wr_i=1 → wr_o stays 0, err_o pulses 1 cycle after the request.
  - A second wr_i during busy_o=1 is dropped: no second done_o or err_o.
- Reset mid-transfer:
  - rst_n_i low during WAIT → wr_o and busy_o go to 0 asynchronously, with no done_o/err_o.
  - After release, a new request completes normally.
